// File: rtl/rr_arbiter_bin_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_bin_grant
// Purpose  : Round-robin arbiter over ONE_HOT_W requesters. Presents the
//            winner as a registered binary index with a valid/ready
//            handshake. A rotating priority pointer advances past every
//            accepted grant, so fairness holds under continuous contention.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_bin_grant #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 1 << BIN_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ONE_HOT_W-1:0] req_i,
  output logic                 grant_valid_o,
  input  logic                 grant_ready_i,
  output logic [BIN_W-1:0]     grant_idx_o,
  output logic [BIN_W-1:0]     ptr_o
);

  // The index arithmetic relies on natural BIN_W wrap, so the requester
  // count must fill the index space exactly.
  if (ONE_HOT_W != (1 << BIN_W)) begin : g_bad_width
    $error("rr_arbiter_bin_grant: ONE_HOT_W must equal 1<<BIN_W");
  end

  // IDLE: no grant pending. HOLD: idx_q is a grant waiting to be taken.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] ptr_q, ptr_d;
  logic [BIN_W-1:0] idx_q, idx_d;

  logic             any_req;
  logic [BIN_W-1:0] next_after_idx;
  logic [BIN_W-1:0] arb_base;
  logic [BIN_W-1:0] winner;
  logic             found;

  assign any_req        = |req_i;
  assign next_after_idx = idx_q + BIN_W'(1);

  // On a transfer the search restarts just past the grant being accepted,
  // which is what allows back-to-back grants without a bubble cycle.
  assign arb_base = (state_q == HOLD) ? next_after_idx : ptr_q;

  // Cyclic priority search starting at arb_base; the sum wraps in BIN_W bits.
  always_comb begin
    winner = arb_base;
    found  = 1'b0;
    for (int i = 0; i < ONE_HOT_W; i++) begin
      logic [BIN_W-1:0] cand;
      cand = arb_base + BIN_W'(i);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic: grants are sticky while the consumer is not ready.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          idx_d   = winner;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (grant_ready_i) begin
          ptr_d = next_after_idx;
          if (any_req) begin
            idx_d = winner;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any pending grant immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs come straight from registers.
  assign grant_valid_o = (state_q == HOLD);
  assign grant_idx_o   = idx_q;
  assign ptr_o         = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_bin_grant.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_bin_grant
// Purpose  : Self-checking bench for rr_arbiter_bin_grant (BIN_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_bin_grant;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        rdy = 1'b0;
  logic        valid;
  logic [3:0]  idx;
  logic [3:0]  ptr;

  int errors = 0;
  int checks = 0;

  // Expected {valid, idx, ptr} after each driven clock edge.
  logic [8:0] sb[$];

  // Reference model state.
  logic       m_vld;
  logic [3:0] m_idx;
  logic [3:0] m_ptr;

  rr_arbiter_bin_grant #(.BIN_W(4), .ONE_HOT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .grant_valid_o (valid),
    .grant_ready_i (rdy),
    .grant_idx_o   (idx),
    .ptr_o         (ptr)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: compares each edge's result shortly after the edge.
  always @(posedge clk) begin
    logic [8:0] e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({valid, idx, ptr} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got vld=%0b idx=%0d ptr=%0d, want vld=%0b idx=%0d ptr=%0d",
                 $time, valid, idx, ptr, e[8], e[7:4], e[3:0]);
      end
    end
  end

  function automatic logic [3:0] pick(input logic [15:0] r, input logic [3:0] base);
    for (int k = 0; k < 16; k++) begin
      if (r[(int'(base) + k) % 16]) return 4'((int'(base) + k) % 16);
    end
    return base;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic drive(input logic [15:0] r, input logic rd);
    logic [3:0] nb;
    req = r;
    rdy = rd;
    if (!m_vld) begin
      if (|r) begin
        m_idx = pick(r, m_ptr);
        m_vld = 1'b1;
      end
    end else if (rd) begin
      nb    = m_idx + 4'd1;
      m_ptr = nb;
      if (|r) m_idx = pick(r, nb);
      else    m_vld = 1'b0;
    end
    sb.push_back({m_vld, m_idx, m_ptr});
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req = '0;
    rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_vld = 1'b0;
    m_idx = '0;
    m_ptr = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({valid, idx, ptr} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: got vld=%0b idx=%0d ptr=%0d, want 0/0/0", valid, idx, ptr);
    end
    drive(16'hFFFF, 1'b1);
    drive(16'hFFFF, 1'b1);
    drive(16'hFFFF, 1'b0);
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    @(posedge clk);
    #3;
    req = 16'hFFFF;
    rst = 1'b1;
    #1;
    checks++;
    if ({valid, idx, ptr} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: got vld=%0b idx=%0d ptr=%0d, want 0/0/0", valid, idx, ptr);
    end
    @(negedge clk);
    rst   = 1'b0;
    req   = '0;
    m_vld = 1'b0;
    m_idx = '0;
    m_ptr = '0;
  endtask

  task automatic test_ready_idle();
    apply_reset();
    drive(16'h0000, 1'b1);
    drive(16'h0000, 1'b1);
    checks++;
    if (valid !== 1'b0 || ptr !== 4'd0) begin
      errors++;
      $display("FAIL ready_idle: got vld=%0b ptr=%0d, want 0/0", valid, ptr);
    end
  endtask

  task automatic test_single();
    apply_reset();
    drive(16'h0020, 1'b1);
    checks++;
    if (valid !== 1'b1 || idx !== 4'd5) begin
      errors++;
      $display("FAIL single_grant: got vld=%0b idx=%0d, want 1/5", valid, idx);
    end
    drive(16'h0000, 1'b1);
    checks++;
    if (valid !== 1'b0 || ptr !== 4'd6) begin
      errors++;
      $display("FAIL single_release: got vld=%0b ptr=%0d, want 0/6", valid, ptr);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      drive(16'hFFFF, 1'b1);
      checks++;
      if (valid !== 1'b1 || idx !== 4'(k % 16)) begin
        errors++;
        $display("FAIL sweep[%0d]: got vld=%0b idx=%0d, want 1/%0d", k, valid, idx, k % 16);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive(16'h0008, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(16'h8000, 1'b0);
      checks++;
      if (valid !== 1'b1 || idx !== 4'd3) begin
        errors++;
        $display("FAIL backpressure[%0d]: got vld=%0b idx=%0d, want 1/3", k, valid, idx);
      end
    end
    drive(16'h8000, 1'b1);
    checks++;
    if (valid !== 1'b1 || idx !== 4'd15 || ptr !== 4'd4) begin
      errors++;
      $display("FAIL backpressure_release: got vld=%0b idx=%0d ptr=%0d, want 1/15/4", valid, idx, ptr);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(16'h4000, 1'b1);
    drive(16'h0000, 1'b1);
    checks++;
    if (ptr !== 4'd15 || valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_setup: got vld=%0b ptr=%0d, want 0/15", valid, ptr);
    end
    for (int k = 0; k < 5; k++) begin
      drive(16'h8001, 1'b1);
      checks++;
      if (valid !== 1'b1 || idx !== ((k % 2 == 0) ? 4'd15 : 4'd0)) begin
        errors++;
        $display("FAIL wrap_alt[%0d]: got vld=%0b idx=%0d, want 1/%0d", k, valid, idx,
                 (k % 2 == 0) ? 15 : 0);
      end
    end
  endtask

  task automatic test_sticky();
    apply_reset();
    drive(16'h0080, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(16'h0000, 1'b0);
      checks++;
      if (valid !== 1'b1 || idx !== 4'd7) begin
        errors++;
        $display("FAIL sticky[%0d]: got vld=%0b idx=%0d, want 1/7", k, valid, idx);
      end
    end
    drive(16'h0000, 1'b1);
    checks++;
    if (valid !== 1'b0 || ptr !== 4'd8 || idx !== 4'd7) begin
      errors++;
      $display("FAIL sticky_release: got vld=%0b idx=%0d ptr=%0d, want 0/7/8", valid, idx, ptr);
    end
  endtask

  initial begin
    m_vld = 1'b0;
    m_idx = '0;
    m_ptr = '0;
    test_reset();
    test_ready_idle();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_sticky();
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_bin_grant.md
Name: rr_arbiter_bin_grant

Overview:
Round-robin arbiter for ONE_HOT_W requesters. It emits the winning requester as a registered binary index with a valid/ready handshake. It sits directly upstream of Binary_to_Onehot: grant_idx_o drives that block's bin_i, which re-expands the index to a one-hot select for downstream muxing. Fairness is guaranteed by a rotating priority pointer that advances past each accepted grant.

Parameters:
BIN_W, 4, width of the binary grant index
ONE_HOT_W, 1<<BIN_W, number of requesters; must equal 1<<BIN_W (elaboration-time $error otherwise)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-high
req_i  input  ONE_HOT_W  request vector, bit n = requester n wants a grant
grant_valid_o  output  1  grant_idx_o holds a valid grant
grant_ready_i  input  1  consumer accepts grant this cycle
grant_idx_o  output  BIN_W  binary index of granted requester
ptr_o  output  BIN_W  current highest-priority index (debug/observability)

Behaviour:
- Reset (async assert, sync deassert by the system): grant_valid_o=0, grant_idx_o=0, ptr_o=0. Reset mid-transfer drops the pending grant; no transfer is counted.
- State is held in ptr_q (BIN_W), idx_q (BIN_W) and vld_q (1). There are two states: IDLE (vld_q=0) and HOLD (vld_q=1).
- Arbitration is combinational. From a base pointer p, the winner is the first n in the cyclic order p, p+1, …, ONE_HOT_W-1, 0, …, p-1 with req_i[n]=1. Index arithmetic is mod ONE_HOT_W, i.e. natural BIN_W wrap.
- IDLE: if |req_i=1, arbitrate with base=ptr_q, load idx_q with the winner and set vld_q=1 on the next edge. Latency is 1 cycle from request to grant_valid_o. If req_i=0, remain in IDLE.
- HOLD, grant_ready_i=0: idx_q and vld_q are held unchanged. Changes on req_i, including the granted requester dropping its request, are ignored; grants are sticky.
- HOLD, grant_ready_i=1 (transfer):
  - ptr_q <= idx_q+1 (wrap: ONE_HOT_W-1 -> 0).
  - If |req_i=1 in the same cycle, arbitrate with base=idx_q+1 and load the new winner; vld_q stays 1. This gives back-to-back grants, one per cycle, with no bubble.
  - If req_i=0, vld_q <= 0 and idx_q holds its last value.
- grant_ready_i while vld_q=0 is ignored. ptr_q changes only on a transfer.
- Single persistent requester n: it is granted every cycle while ready=1, and ptr_q = n+1 after each transfer.
- All requesters asserted with ready=1 continuously: grants are issued as 0,1,…,ONE_HOT_W-1,0,… in order.
- The outputs are direct register outputs, with no combinational path from req_i or grant_ready_i to any output.

Test Plan:
- Reset: assert rst_i mid-cycle with req_i=16'hFFFF -> grant_valid_o=0, grant_idx_o=0 and ptr_o=0 immediately, without waiting for a clock edge.
- Single request: req_i=16'h0020, ready=1 -> grant_valid_o=1 one cycle later with grant_idx_o=5; after the transfer ptr_o=6. Then req_i=0 -> grant_valid_o=0 the following cycle.
- Round-robin sweep: req_i=16'hFFFF with ready held at 1 for 20 cycles -> grant_idx_o sequence 0,1,…,15,0,1,2,3 with no bubbles. Feeding this into Binary_to_Onehot gives one_hot_o = 1<<idx, and $countones = 1 every cycle.
- Backpressure: grant idx=3 with ready=0 for 5 cycles while req_i changes to 16'h8000 -> grant_idx_o=3 and valid stay stable throughout. With ready=1, the grant transfers and the next grant is idx=15.
- Wrap/fairness: ptr=15 with req_i=16'h8001 -> grant 15 first; after that transfer, grant 0; after that transfer, grant 15. The two requesters alternate strictly.
- Sticky grant: grant idx=7 pending with ready=0, then req_i[7] drops to 0 -> grant_idx_o remains 7 until the transfer, after which ptr_o=8.
